// File: rtl/lcd_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_io_responder
// Purpose  : Device-side responder for the CPU's memory-mapped LCD register.
//            A rising edge on the EN strobe bit of the LSU's LCD word starts a
//            character-LCD bus cycle: setup, enable pulse, hold, and an
//            execution wait sized by the command. One extra command can be
//            queued while a cycle is running; further commands are dropped
//            and recorded in a sticky overflow flag.
// Ports    : clk_i, rst_i        clock, asynchronous active-high reset
//            io_lcd_i            LCD register word ([31] ON, [11] overflow
//                                clear, [10] EN strobe, [9] RS, [8] RW,
//                                [7:0] data)
//            lcd_data_i          data bus read back from the LCD pins
//            lcd_data_o/_oe_o    data bus drive and output enable
//            lcd_rs_o/rw_o/en_o  LCD control pins
//            lcd_on_o            LCD power/backlight
//            lcd_done_o          one-cycle pulse at the end of a transaction
//            status_o            {busy, pending, overflow, 0..., rd_data[7:0]}
// Revision : 1.0 - initial release
// ============================================================================
module lcd_io_responder #(
    parameter int Width     = 32,
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 80000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] io_lcd_i,
    input  logic [7:0]       lcd_data_i,
    output logic [7:0]       lcd_data_o,
    output logic             lcd_data_oe_o,
    output logic             lcd_rs_o,
    output logic             lcd_rw_o,
    output logic             lcd_en_o,
    output logic             lcd_on_o,
    output logic             lcd_done_o,
    output logic [Width-1:0] status_o
);

    // Counter width covers the largest phase length.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HE  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_A   = (MAX_SP > MAX_HE) ? MAX_SP : MAX_HE;
    localparam int MAX_ALL = (MAX_A > LONG_CYC) ? MAX_A : LONG_CYC;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_pulse_ld = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_ld  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_exec_ld  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] c_long_ld  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    // Command layout: [9] RS, [8] RW, [7:0] data.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       cmd_q, cmd_d;
    logic [9:0]       cap_q, cap_d;
    logic [9:0]       pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       rd_q, rd_d;
    logic             en_s_q, en_s_d;
    logic             en_prev_q, en_prev_d;
    logic             on_q, on_d;

    logic             w_rise;
    logic             w_busy;
    logic             w_exit;
    logic             w_long;
    logic             w_ovf_set;

    // Bits of the register word this block does not decode.
    logic             unused_io_bits;
    assign unused_io_bits = ^io_lcd_i[Width-2:12];

    // The strobe is sampled into en_s_q and acted on one cycle later; the
    // command fields are captured on the same edge that samples the strobe
    // so they line up with the detected rise.
    assign w_rise = en_s_q & ~en_prev_q;
    assign w_busy = (state_q != S_IDLE);
    assign w_exit = (state_q == S_EXEC) && (cnt_q == '0);
    assign w_long = ~cmd_q[9] & ~cmd_q[8] &
                    ((cmd_q[7:0] == 8'h01) || (cmd_q[7:0] == 8'h02) ||
                     (cmd_q[7:0] == 8'h03));

    always_comb begin
        en_s_d    = io_lcd_i[10];
        en_prev_d = en_s_q;
        cap_d     = (io_lcd_i[10] & ~en_s_q) ? io_lcd_i[9:0] : cap_q;
        on_d      = io_lcd_i[Width-1];
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        rd_d      = rd_q;
        w_ovf_set = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    state_d = S_SETUP;
                    cnt_d   = c_setup_ld;
                    cmd_d   = cap_q;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = c_pulse_ld;
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    if (cmd_q[8]) begin
                        rd_d = lcd_data_i;
                    end
                    state_d = S_HOLD;
                    cnt_d   = c_hold_ld;
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = w_long ? c_long_ld : c_exec_ld;
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    if (pend_v_q) begin
                        // Queued command starts with no idle gap; a rise in
                        // this same cycle refills the slot just vacated.
                        state_d  = S_SETUP;
                        cnt_d    = c_setup_ld;
                        cmd_d    = pend_q;
                        pend_v_d = w_rise;
                        if (w_rise) begin
                            pend_d = cap_q;
                        end
                    end else if (w_rise) begin
                        // Rise at the exit with an empty slot starts directly
                        // rather than parking in the slot and idling.
                        state_d = S_SETUP;
                        cnt_d   = c_setup_ld;
                        cmd_d   = cap_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Rise during a running transaction (other than the exit cycle).
        if (w_rise && w_busy && !w_exit) begin
            if (!pend_v_q) begin
                pend_d   = cap_q;
                pend_v_d = 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end

        // Set has priority over the level-sensitive clear.
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (io_lcd_i[11]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            cap_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            en_s_q    <= 1'b0;
            en_prev_q <= 1'b0;
            on_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            cap_q     <= cap_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            en_s_q    <= en_s_d;
            en_prev_q <= en_prev_d;
            on_q      <= on_d;
        end
    end

    // Bus outputs decode directly from registered state so an asynchronous
    // reset drops EN immediately.
    assign lcd_rs_o      = w_busy & cmd_q[9];
    assign lcd_rw_o      = w_busy & cmd_q[8];
    assign lcd_data_o    = w_busy ? cmd_q[7:0] : 8'h00;
    assign lcd_data_oe_o = w_busy & ~cmd_q[8];
    assign lcd_en_o      = (state_q == S_PULSE);
    assign lcd_on_o      = on_q;
    assign lcd_done_o    = w_exit;
    assign status_o      = {w_busy, pend_v_q, ovf_q, {(Width-11){1'b0}}, rd_q};

endmodule
`default_nettype wire

// File: doc/lcd_io_responder.md
Name: lcd_io_responder

Overview:
- Device-side responder for the CPU's memory-mapped LCD output register.
- Watches the 32-bit LCD word that the LSU drives. On each software-generated strobe it runs a correctly timed character-LCD bus cycle (setup, enable pulse, hold, execution wait).
- Exposes busy, read-data and error status so software can poll it through the switch/input path.
- Sits between the LSU's LCD output register and the board LCD pins.

Parameters:
Width, 32, width of the LCD register word and of the status word
SETUP_CYC, 4, cycles of RS/RW/data valid before EN rises (≥1)
PULSE_CYC, 12, cycles EN is held high (≥1)
HOLD_CYC, 4, cycles bus is held after EN falls (≥1)
EXEC_CYC, 2000, wait cycles after HOLD for normal commands and data
LONG_CYC, 80000, wait cycles after HOLD for clear/home commands

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
io_lcd_i  in  Width  LCD register word; [31]=ON, [11]=overflow clear, [10]=EN strobe, [9]=RS, [8]=RW, [7:0]=data
lcd_data_i  in  8  data bus read back from the LCD pins
lcd_data_o  out  8  data bus driven to the LCD
lcd_data_oe_o  out  1  data bus output enable
lcd_rs_o  out  1  register select
lcd_rw_o  out  1  read/write (1 = read)
lcd_en_o  out  1  LCD enable pulse
lcd_on_o  out  1  LCD power/backlight
lcd_done_o  out  1  one-cycle pulse when a transaction completes
status_o  out  Width  {busy, pending, overflow, 21'b0, rd_data[7:0]}

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE; all counters 0; edge register 0; pending slot empty; overflow 0; rd_data 0.
  - All outputs 0, including lcd_en_o, which drops immediately even mid-pulse.
  - The first rising clock edge after reset release does nothing but sample the edge register.
- lcd_on_o: io_lcd_i[31] registered once; independent of the FSM.
- Strobe detection:
  - EN rise is io_lcd_i[10]=1 with previous sampled value 0.
  - On a rise, {RS, RW, data} is captured in the same cycle.
  - A level held high never re-triggers.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
  - IDLE + rise → SETUP on the next edge. The command register loads from the capture.
  - SETUP: lcd_rs_o, lcd_rw_o and lcd_data_o are driven from the command register. lcd_data_oe_o = ~RW. Lasts exactly SETUP_CYC cycles, then PULSE.
  - PULSE: lcd_en_o=1 for exactly PULSE_CYC cycles. If RW=1, lcd_data_i is sampled into rd_data on the last PULSE cycle. Then HOLD.
  - HOLD: lcd_en_o=0; RS/RW/data still held. Lasts HOLD_CYC cycles, then EXEC.
  - EXEC: bus outputs are held. Wait length is LONG_CYC if RS=0, RW=0 and data ∈ {0x01, 0x02, 0x03}; otherwise EXEC_CYC.
  - At the end of EXEC, lcd_done_o pulses for one cycle. If pending is valid, go directly to SETUP with the pending command and clear pending; otherwise go to IDLE.
  - Back-to-back latency from EXEC end to next SETUP is 0 extra cycles.
- Latency: strobe-sample edge to lcd_en_o high is 1+SETUP_CYC cycles.
- busy = (state≠IDLE). In IDLE, bus outputs are 0 and oe is 0.
- Pending slot (1 deep):
  - A rise while busy loads pending if it is empty.
  - A rise while busy with pending full discards the new command and sets overflow (sticky).
  - A rise in the same cycle as the EXEC exit that consumes pending is stored into the now-free slot, and overflow is not set.
- Overflow clearing:
  - io_lcd_i[11]=1 (level) clears overflow.
  - If a clear and a new overflow occur in the same cycle, set wins.
- Counters: width is ceil(log2(max param+1)). Counters load to param-1 on state entry and decrement to 0. No wrap-around beyond 0.
- lcd_data_i is sampled only in a read PULSE. rd_data otherwise holds its value.

Test Plan:
- Reset mid-PULSE: assert rst_i while lcd_en_o=1 → lcd_en_o=0 combinationally; status_o=0; no lcd_done_o after release.
- Single write (params 4/12/4/20/100): io_lcd_i=0x8000_0641 (ON, EN, RS, data 0x41) → lcd_on_o=1. lcd_en_o high from cycle 5 to cycle 16 after the strobe sample. RS=1, data=0x41, oe=1 throughout. lcd_done_o at cycle 40. busy clears the following cycle.
- Clear command: data 0x01, RS=0, RW=0 → EXEC lasts 100 cycles instead of 20. Done arrives 80 cycles later than in the write case.
- Read: RW=1, RS=0, lcd_data_i=0x80 during PULSE → oe=0; status_o[7:0]=0x80 after PULSE.
- Queueing: three EN rises during one transaction → second executes back-to-back with 0 idle cycles. Third sets status_o[29]. Writing [11]=1 clears it.
- EN held high for 50 cycles → exactly one transaction and one lcd_done_o pulse.
